div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_pkg.sv | 10 +
 rtl/div_core.sv | 39 +++
 rtl/div_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and constants for the two-requester divider scheduler.
package div_pkg;
    localparam int unsigned NW    = 10;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = $clog2(NW + 1);

    localparam logic [NW-1:0] DZ_QUO = {NW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: load strobe, one shift-subtract per step, MSB first.
module div_core
    import div_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [NW-1:0] i_num,
    input  logic [DW-1:0] i_den,
    output logic [NW-1:0] o_quo,
    output logic [NW-1:0] o_rem
);
    // The partial remainder stays below den, so DW+1 bits hold every shifted trial value.
    logic [DW:0]   r_prem;
    logic [NW-1:0] r_qsh;
    logic [DW-1:0] r_den;
    logic [DW:0]   w_trial;
    logic          w_fit;

    always_comb begin
        w_trial = {r_prem[DW-1:0], r_qsh[NW-1]};
        w_fit   = (w_trial >= {1'b0, r_den});
    end

    always_ff @(posedge i_clock) begin
        if (i_load) begin
            r_prem <= '0;
            r_qsh  <= i_num;
            r_den  <= i_den;
        end else if (i_step) begin
            r_prem <= w_fit ? (w_trial - {1'b0, r_den}) : w_trial;
            r_qsh  <= {r_qsh[NW-2:0], w_fit};
        end
    end

    // Before the first step r_qsh still holds the numerator.
    assign o_quo = r_qsh;
    assign o_rem = NW'(r_prem);
endmodule

// File: rtl/div_sched.sv
// Round-robin arbiter and IDLE/RUN/DONE sequencer sharing one div_core between two requesters.
module div_sched
    import div_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic [NW-1:0] i_num0,
    input  logic [NW-1:0] i_num1,
    input  logic [DW-1:0] i_den0,
    input  logic [DW-1:0] i_den1,
    output logic          o_ack0,
    output logic          o_ack1,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_done_id,
    output logic [NW-1:0] o_quo,
    output logic [NW-1:0] o_rem,
    output logic          o_dz
);
    state_t           r_state;
    state_t           w_state_d;
    logic             r_last;
    logic             r_id;
    logic             r_den_zero;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_done_id;
    logic             r_dz;
    logic [NW-1:0]    r_quo;
    logic [NW-1:0]    r_rem;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic [NW-1:0]    w_num;
    logic [DW-1:0]    w_den;
    logic [NW-1:0]    w_core_quo;
    logic [NW-1:0]    w_core_rem;

    assign w_load = w_grant0 | w_grant1;
    assign w_num  = w_grant1 ? i_num1 : i_num0;
    assign w_den  = w_grant1 ? i_den1 : i_den0;

    always_comb begin
        w_state_d = r_state;
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_step    = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                // r_last = 1 means requester 1 was served last, so requester 0 wins a tie.
                if (i_req0 && (!i_req1 || r_last)) begin
                    w_grant0 = 1'b1;
                end else if (i_req1) begin
                    w_grant1 = 1'b1;
                end
                if (w_grant0 || w_grant1) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                // A zero divisor finishes on the first RUN cycle without iterating.
                if (r_den_zero || (r_cnt == CNT_W'(NW))) begin
                    w_finish  = 1'b1;
                    w_state_d = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_den_zero <= 1'b0;
            r_cnt      <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_done_id  <= 1'b0;
            r_dz       <= 1'b0;
            r_quo      <= '0;
            r_rem      <= '0;
        end else begin
            r_state <= w_state_d;
            r_ack0  <= w_grant0;
            r_ack1  <= w_grant1;
            if (w_load) begin
                r_last     <= w_grant1;
                r_id       <= w_grant1;
                r_den_zero <= (w_den == '0);
                r_cnt      <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_done_id <= r_id;
                r_dz      <= r_den_zero;
                r_quo     <= r_den_zero ? DZ_QUO : w_core_quo;
                r_rem     <= r_den_zero ? w_core_quo : w_core_rem;
            end
        end
    end

    div_core u_core (
        .i_clock (i_clock),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_num   (w_num),
        .i_den   (w_den),
        .o_quo   (w_core_quo),
        .o_rem   (w_core_rem)
    );

    assign o_ack0    = r_ack0;
    assign o_ack1    = r_ack1;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);
    assign o_done_id = r_done_id;
    assign o_quo     = r_quo;
    assign o_rem     = r_rem;
    assign o_dz      = r_dz;
endmodule
